// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment counter display path: digit width,
// active-low segment patterns (bit order a..g) and the decode helper.
package seg_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] BLANK = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] seg_decode(input logic [DIGIT_W-1:0] d);
    return SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable tick generator: counts while en=1 and pulses tick for one cycle
// when the count reaches the run-time limit, then restarts from zero.
module tick_gen #(
  parameter int DIV = 4,
  parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // >= rather than == so that lowering the limit mid-count fires at once
  // instead of running all the way around the counter.
  always_comb begin
    tick  = en && (cnt_q >= limit);
    cnt_d = cnt_q + 1'b1;
    if (rst || !en || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_counter_mux.sv
// Multi-digit up/down BCD or hex counter driving a time-multiplexed
// common-anode 7-segment display; all pacing comes from clock-enable ticks.
import seg_pkg::*;

module seg_counter_mux #(
  parameter int DIGITS    = 4,
  parameter int RADIX_BCD = 1,
  parameter int SLOW_DIV  = 67_000_000,
  parameter int FAST_DIV  = 20_000_000,
  parameter int SCAN_DIV  = 100_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        speed,
  input  logic                        mode,
  input  logic                        load,
  input  logic [DIGIT_W*DIGITS-1:0]   load_val,
  output logic [DIGIT_W*DIGITS-1:0]   count,
  output logic                        tc,
  output logic [6:0]                  a_to_g,
  output logic [DIGITS-1:0]           an,
  output logic                        dp
);

  localparam int N       = DIGIT_W * DIGITS;
  localparam int CNT_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW      = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam int SW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGIT_W-1:0] MAX_DIG = (RADIX_BCD != 0) ? 4'd9 : 4'hF;

  logic [CW-1:0]        cnt_limit;
  logic                 cnt_tick;
  logic                 scan_tick;

  logic [N-1:0]         count_q, count_d;
  logic [N-1:0]         step_val, load_sat, rst_val;
  logic                 carry;
  logic                 tc_q, tc_d;

  logic [IW-1:0]        idx_q, idx_d;
  logic [DIGIT_W-1:0]   dig_sel;
  logic                 dig_ok;
  logic [DIGITS-1:0]    an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  assign cnt_limit = speed ? CW'(FAST_DIV - 1) : CW'(SLOW_DIV - 1);

  tick_gen #(.DIV(CNT_DIV), .W(CW)) u_cnt_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .limit (cnt_limit),
    .tick  (cnt_tick)
  );

  tick_gen #(.DIV(SCAN_DIV), .W(SW)) u_scan_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .limit (SW'(SCAN_DIV - 1)),
    .tick  (scan_tick)
  );

  // Ripple step: carry/borrow propagates while each digit wraps; a carry out
  // of the top digit means the whole count wrapped.
  always_comb begin
    step_val = count_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (!mode) begin
          if (count_q[i*DIGIT_W +: DIGIT_W] == MAX_DIG) begin
            step_val[i*DIGIT_W +: DIGIT_W] = '0;
          end else begin
            step_val[i*DIGIT_W +: DIGIT_W] = count_q[i*DIGIT_W +: DIGIT_W] + 1'b1;
            carry = 1'b0;
          end
        end else begin
          if (count_q[i*DIGIT_W +: DIGIT_W] == '0) begin
            step_val[i*DIGIT_W +: DIGIT_W] = MAX_DIG;
          end else begin
            step_val[i*DIGIT_W +: DIGIT_W] = count_q[i*DIGIT_W +: DIGIT_W] - 1'b1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    load_sat = load_val;
    rst_val  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((RADIX_BCD != 0) && (load_val[i*DIGIT_W +: DIGIT_W] > 4'd9)) begin
        load_sat[i*DIGIT_W +: DIGIT_W] = 4'd9;
      end
      if (mode) begin
        rst_val[i*DIGIT_W +: DIGIT_W] = MAX_DIG;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (rst) begin
      count_d = rst_val;
    end else if (load) begin
      count_d = load_sat;
    end else if (cnt_tick && en) begin
      count_d = step_val;
      tc_d    = carry;
    end
  end

  // Display registers are fed from the next index so anode and segments
  // switch on the same edge; segments follow the registered count.
  always_comb begin
    idx_d = idx_q;
    if (rst) begin
      idx_d = '0;
    end else if (scan_tick) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    dig_sel = '0;
    dig_ok  = 1'b0;
    an_d    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        dig_sel = count_q[i*DIGIT_W +: DIGIT_W];
        dig_ok  = 1'b1;
        an_d[i] = 1'b0;
      end
    end

    if (rst) begin
      seg_d = seg_decode(mode ? MAX_DIG : 4'd0);
    end else begin
      seg_d = dig_ok ? seg_decode(dig_sel) : BLANK;
    end
    dp_d = !(speed && (idx_d == '0));
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    tc_q    <= tc_d;
    idx_q   <= idx_d;
    an_q    <= an_d;
    seg_q   <= seg_d;
    dp_q    <= dp_d;
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign a_to_g = seg_q;
  assign an     = an_q;
  assign dp     = dp_q;

endmodule

// File: doc/seg_counter_mux.md
# seg_counter_mux

Multi-digit up/down counter driving a time-multiplexed common-anode 7-segment display, all in the single `clk` domain. Count and scan timing come from clock-enable ticks, not derived clocks. The block sits directly behind the board I/O (switches in, segment/anode pins out) and replaces the single-digit hex counter display path. Digit count, radix and tick rates are parameters.

## Interface
- DIGITS, 4: number of 4-bit digits counted and displayed (1..8).
- RADIX_BCD, 1: 1 = each digit counts 0..9; 0 = each digit counts 0..F.
- SLOW_DIV, 67_000_000: clk cycles per count tick when speed=0.
- FAST_DIV, 20_000_000: clk cycles per count tick when speed=1.
- SCAN_DIV, 100_000: clk cycles per display digit step.

Ports:
- clk  in  1  clock; every register is clocked on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable.
- speed  in  1  0 = SLOW_DIV tick, 1 = FAST_DIV tick.
- mode  in  1  0 = up, 1 = down.
- load  in  1  synchronous parallel load strobe.
- load_val  in  4*DIGITS  value to load; digit 0 is in bits [3:0].
- count  out  4*DIGITS  current count, registered.
- tc  out  1  one-cycle terminal-count (wrap) pulse.
- a_to_g  out  7  segments a..g, active-low.
- an  out  DIGITS  anode selects, active-low, one-hot.
- dp  out  1  decimal point, active-low.

## Operation
- Count prescaler:
  - Increments every cycle while en=1. Held at 0 while en=0.
  - When the prescaler is ≥ the selected DIV−1, it clears and asserts a one-cycle internal tick. Use ≥, not ==, so that switching speed never causes a long rollover.
- Count update, in priority order:
  1. rst: count = all-zero if mode=0; all-max if mode=1 (all 9s in BCD, all Fs in hex). Prescaler, scan counter and digit index clear. tc=0.
  2. load: count = load_val. In BCD mode any digit >9 is loaded as 9. A coincident tick is discarded. tc=0.
  3. tick with en=1: ripple increment or decrement.
     - Up: digit at max → 0 with carry to the next digit.
     - Down: digit at 0 → max with borrow.
- Wrap and tc:
  - Up from all-max gives all-zero; down from all-zero gives all-max.
  - tc is asserted for the same cycle in which the wrapped count appears.
- Mode change takes effect at the next tick. The count is not reset.
- Display scan:
  - The scan prescaler runs continuously and is independent of en.
  - On each scan tick, the digit index advances 0→1→…→DIGITS−1→0.
  - an = ~(1 << index).
  - a_to_g = decode(digit[index]) using the team's pattern set:
    - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
    - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- dp = 0 (lit) only when index=0 and speed=1 (fast-mode indicator); otherwise 1.

## Timing
- Reset values, visible the cycle after rst is sampled:
  - count per mode.
  - tc=0, an = ~1 (digit 0 selected), dp=1 unless speed=1.
  - a_to_g = pattern of digit 0 of the reset count: 0000001 for up; 0000100 for BCD down; 0111000 for hex down.
- First count tick: count changes DIV clk cycles after the first cycle with en=1 and rst=0.
- Count changes exactly one cycle after the internal tick (registered).
- an, a_to_g and dp are registered and change together one cycle after the scan tick, so there is no cross-digit ghosting.
- A count change on the currently displayed digit reaches a_to_g one cycle after count changes.
- rst mid-operation overrides load and tick in the same cycle.

## Structure
- Package seg_pkg holds:
  - the 16-entry active-low segment constant array and a seg_decode function;
  - the BLANK pattern (1111111);
  - the digit-width constant (4).
- Sub-module tick_gen (parameter DIV; ports clk, rst, en, sel-limit, tick) is instantiated twice: once for the count tick and once for the scan tick (scan instance en tied high).
- The ripple counter and the scan mux stay in the top module.

## Test plan
All scenarios use DIGITS=4, SLOW_DIV=8, FAST_DIV=4, SCAN_DIV=2 and RADIX_BCD=1 unless stated.
- rst, then mode=0, speed=1, en=1 → count 0000→0001 after 4 cycles; from 0009 the next tick gives 0010; tc stays 0.
- Load 0000 with mode=1, then one tick → count 9999 with a one-cycle tc pulse in the same cycle.
- load=1 with load_val=12F4, asserted in the tick cycle → count 1294 and the tick is ignored. With RADIX_BCD=0, the same load gives 12F4.
- Count 1234 held, en=0 → an cycles 1110, 1101, 1011, 0111 every 2 cycles, with a_to_g 1001100, 0000110, 0010010, 1001111 respectively. dp=0 only on 1110 when speed=1.
- RADIX_BCD=0, count 00FF, up tick → 0100. Toggle speed from 0 to 1 when the prescaler is at 6 → tick fires on the next cycle.
- rst asserted mid-count with mode=1 → count 9999, an=1110, a_to_g=0000100, and the prescaler restarts from 0.
